// File: rtl/module_booth_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential Booth multiplier core
// between two requesters, with a WAIT watchdog and per-requester response handshake.
module module_booth_arbiter #(
  parameter int N           = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [N-1:0]   req_a0,
  input  logic [N-1:0]   req_b0,
  input  logic [N-1:0]   req_a1,
  input  logic [N-1:0]   req_b1,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [2*N-1:0] rsp_product,
  output logic           rsp_err,
  output logic [N-1:0]   mul_a,
  output logic [N-1:0]   mul_b,
  output logic           mul_init,
  input  logic           mul_done,
  input  logic [2*N-1:0] mul_product,
  output logic           busy,
  output logic [1:0]     dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and requesters hold data until ready.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int CW = $clog2(TIMEOUT_CYC);

  state_t        state_q, state_d;
  logic          last_grant;
  logic          owner;
  logic [CW-1:0] counter;

  logic grant;
  logic accept;
  logic timeout;

  // Contention goes to whoever did not win last time; a sole requester always wins.
  always_comb begin
    grant = req_valid[1];
    if (req_valid == 2'b11) grant = ~last_grant;
  end

  assign accept  = (state_q == IDLE) && (|req_valid);
  assign timeout = (state_q == WAIT) && !mul_done && (counter == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    req_ready = 2'b00;
    if (accept) req_ready = grant ? 2'b10 : 2'b01;
  end

  assign rsp_valid = (state_q == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign mul_init  = (state_q == START);
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = START;
      START: state_d = WAIT;
      WAIT:  if (mul_done || timeout) state_d = RESP;
      RESP:  if (rsp_ready[owner]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      counter     <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_product <= '0;
      rsp_err     <= 1'b0;
    end else begin
      if (accept) begin
        mul_a      <= grant ? req_a1 : req_a0;
        mul_b      <= grant ? req_b1 : req_b0;
        owner      <= grant;
        last_grant <= grant;
        counter    <= '0;
      end
      if (state_q == WAIT) begin
        counter <= counter + 1'b1;
        // A completion in the final watchdog cycle still counts as success.
        if (mul_done) begin
          rsp_product <= mul_product;
          rsp_err     <= 1'b0;
        end else if (timeout) begin
          rsp_product <= '0;
          rsp_err     <= 1'b1;
        end
      end
    end
  end

endmodule
